// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment scanner with tear-free, frame-aligned updates.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [PW-1:0] psc_q, psc_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   val_q, val_d, pval_q, pval_d;
  logic [3:0]    dpr_q, dpr_d, pdp_q, pdp_d;
  logic          pend_q, pend_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;
  logic          tick, wrap;
  logic [3:0]    nib, blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign blank = {val_q[15:12] == 4'h0 && !dpr_q[3],
                  val_q[15:8] == 8'h0 && !dpr_q[2],
                  val_q[15:4] == 12'h0 && !dpr_q[1],
                  1'b0};
`else
  assign blank = 4'b0000;
`endif
  // Display register only changes on the 3->0 wrap; a load on that same tick bypasses pending.
  always_comb begin
    tick   = psc_q == LAST;
    wrap   = tick && dig_q == 2'd3;
    psc_d  = tick ? '0 : psc_q + PW'(1);
    dig_d  = tick ? dig_q + 2'd1 : dig_q;
    val_d  = (wrap && load) ? value : (wrap && pend_q) ? pval_q : val_q;
    dpr_d  = (wrap && load) ? dp_in : (wrap && pend_q) ? pdp_q : dpr_q;
    pval_d = load ? value : pval_q;
    pdp_d  = load ? dp_in : pdp_q;
    pend_d = !wrap && (load || pend_q);
    nib    = val_q[{dig_q, 2'b00} +: 4];
    seg_d  = SEG_LUT[nib];
    dp_d   = ~dpr_q[dig_q];
    an_d   = (psc_q == '0 || blank[dig_q]) ? 4'hF : ~(4'b0001 << dig_q);
    fd_d   = wrap;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q  <= '0;
      dig_q  <= 2'd0;
      val_q  <= 16'h0;
      dpr_q  <= 4'h0;
      pval_q <= 16'h0;
      pdp_q  <= 4'h0;
      pend_q <= 1'b0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      an_q   <= 4'hF;
      fd_q   <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      dig_q  <= dig_d;
      val_q  <= val_d;
      dpr_q  <= dpr_d;
      pval_q <= pval_d;
      pdp_q  <= pdp_d;
      pend_q <= pend_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver at REFRESH_DIV=4 (16-cycle frames).
module tb_seg7_scan_driver;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0, load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;
  logic [12:0] sb_q [$];
  int          n_cmp = 0, n_err = 0;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic blanked(input int i, input logic [15:0] v, input logic [3:0] d);
    return LZB && ((i == 3 && v[15:12] == 4'h0 && !d[3]) ||
                   (i == 2 && v[15:8] == 8'h0 && !d[2]) ||
                   (i == 1 && v[15:4] == 12'h0 && !d[1]));
  endfunction

  // Expected {frame_done, an, seg, dp} per cycle of one frame displaying v/d.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] d);
    logic [3:0] a;
    for (int i = 0; i < 4; i++) begin
      a = blanked(i, v, d) ? 4'hF : ~(4'b0001 << i);
      for (int c = 0; c < 4; c++)
        sb_q.push_back({i == 3 && c == 3, c == 0 ? 4'hF : a, seg_of(v[i*4 +: 4]), ~d[i]});
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] lv, input logic [3:0] ldp);
    if (ld) begin
      value = lv;
      dp_in = ldp;
      load  = 1'b1;
    end
    @(negedge clk);
    load = 1'b0;
    if (sb_q.size() == 0) check("sb_empty", 1, 0);
    else check("scan", {frame_done, an, seg, dp}, sb_q.pop_front());
  endtask

  task automatic run_frame(input logic [15:0] v, input logic [3:0] d,
                           input int k1, input logic [15:0] v1, input logic [3:0] d1,
                           input int k2, input logic [15:0] v2, input logic [3:0] d2);
    push_frame(v, d);
    for (int k = 0; k < 16; k++)
      if (k == k1) step(1'b1, v1, d1);
      else if (k == k2) step(1'b1, v2, d2);
      else step(1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_dp", dp, 1'b1);
    check("rst_fd", frame_done, 1'b0);
    rst = 1'b1;
    run_frame(16'h0000, 4'h0, 4, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
    run_frame(16'h1234, 4'h0, 0, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
    run_frame(16'h0000, 4'h0, 2, 16'h5555, 4'hF, 5, 16'hABCD, 4'hA);
    run_frame(16'hABCD, 4'hA, 15, 16'hFFFF, 4'h0, -1, 16'h0, 4'h0);
    run_frame(16'hFFFF, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    push_frame(16'hFFFF, 4'h0);
    for (int k = 0; k < 7; k++) step(k == 3, 16'h1111, 4'h3);
    sb_q.delete();
    #3 rst = 1'b0;
    #1;
    check("arst_seg", seg, 7'h7F);
    check("arst_an", an, 4'hF);
    check("arst_dp", dp, 1'b1);
    check("arst_fd", frame_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_frame(16'h0000, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame(16'h0000, 4'h0, 8, 16'h0005, 4'h0, -1, 16'h0, 4'h0);
    run_frame(16'h0005, 4'h0, 3, 16'h0005, 4'b0100, -1, 16'h0, 4'h0);
    run_frame(16'h0005, 4'b0100, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
